dff_pipe: RTL and testbench

Parametrised elastic register pipeline: WIDTH-bit data through DEPTH flip-flop stages, each with its own valid bit and a valid/ready handshake at both ends. It generalises the single-bit clear/preset flip-flop test cells into a register bank that exercises enable-gated flops, asynchronous clear and synchronous flush. It is intended as a mapping and equivalence target for QuickLogic flop inference and as a reusable retiming and buffering stage.

---
 rtl/dff_pipe.sv | 71 +++++++
 tb/tb_dff_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// dff_pipe: elastic WIDTH x DEPTH register pipeline with per-stage valid and valid/ready handshake.
// Define DFF_PIPE_OCC_EN to add the registered occupancy output occ.
module dff_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);
    logic [DEPTH-1:0] v_q, v_d, adv, ld;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic             down_full;

    // A stage advances when something downstream is empty or the whole tail drains.
    always_comb begin
        adv = '0;
        ld = '0;
        down_full = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            down_full = 1'b1;
            for (int j = i + 1; j < DEPTH; j++) down_full = down_full & v_q[j];
            adv[i] = v_q[i] & (!down_full | out_ready);
        end
        in_ready = !flush & (!v_q[0] | adv[0]);
        out_valid = v_q[DEPTH-1] & !flush;
        ld[0] = in_valid & in_ready;
        for (int i = 1; i < DEPTH; i++) ld[i] = !flush & adv[i-1];
        for (int i = 0; i < DEPTH; i++) v_d[i] = flush ? 1'b0 : ld[i] ? 1'b1 : adv[i] ? 1'b0 : v_q[i];
        d_d[0] = ld[0] ? in_data : d_q[0];
        for (int i = 1; i < DEPTH; i++) d_d[i] = ld[i] ? d_q[i-1] : d_q[i];
    end

    assign out_data = d_q[DEPTH-1];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= RST_VAL;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

`ifdef DFF_PIPE_OCC_EN
    localparam int OW = $clog2(DEPTH+1);
    logic [OW-1:0] occ_q, occ_d;

    always_comb occ_d = flush ? '0 : occ_q + OW'(ld[0]) - OW'(out_valid & out_ready);

    assign occ = occ_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) occ_q <= '0;
        else occ_q <= occ_d;
    end
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: drives a DEPTH=4 and a DEPTH=1 dff_pipe in lockstep against a word-position queue model.
module tb_dff_pipe;
    typedef struct {
        logic [7:0] data;
        int         pos;
    } word_t;

    logic       clk = 0, clr_n = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [7:0] in_data = 0;
    logic       ir [2];
    logic       ov [2];
    logic [7:0] od [2];
`ifdef DFF_PIPE_OCC_EN
    logic [2:0] occ4;
    logic [0:0] occ1;
`endif

    int         n_cmp = 0, n_bad = 0;
    word_t      mq [2][$];
    int         npg [2][$];
    logic [7:0] dut_rx [2][$];
    int         dep [2] = '{4, 1};
    logic [7:0] rst_val [2] = '{8'hA5, 8'h3C};
    logic       exp_ir [2];
    logic       exp_ov [2];
    logic [7:0] exp_od [2];

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) u4 (
        .clk(clk), .clr_n(clr_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0])
`ifdef DFF_PIPE_OCC_EN
        , .occ(occ4)
`endif
    );

    dff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h3C)) u1 (
        .clk(clk), .clr_n(clr_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1])
`ifdef DFF_PIPE_OCC_EN
        , .occ(occ1)
`endif
    );

`ifdef DFF_PIPE_OCC_EN
    function automatic int occ_of(int m);
        return m == 0 ? int'(occ4) : int'(occ1);
    endfunction
`endif

    // Each word moves one stage per edge unless the word ahead of it blocks; the oldest may leave.
    task automatic predict();
        for (int m = 0; m < 2; m++) begin
            int lim = out_ready ? dep[m] : dep[m] - 1;
            npg[m].delete();
            for (int k = 0; k < mq[m].size(); k++) begin
                int p = mq[m][k].pos + 1;
                if (p > lim) p = lim;
                npg[m].push_back(p);
                lim = p - 1;
            end
            exp_ov[m] = !flush && mq[m].size() > 0 && mq[m][0].pos == dep[m] - 1;
            exp_od[m] = exp_ov[m] ? mq[m][0].data : 8'h00;
            exp_ir[m] = !flush && (mq[m].size() == 0 || npg[m][npg[m].size()-1] >= 1);
        end
    endtask

    task automatic drive(input bit iv, input logic [7:0] dat, input bit ordy, input bit fl);
        @(negedge clk);
        in_valid = iv;
        in_data = dat;
        out_ready = ordy;
        flush = fl;
        #1;
        predict();
    endtask

    task automatic step();
        bit acc [2];
        for (int m = 0; m < 2; m++) begin
            acc[m] = in_valid && exp_ir[m];
            if (ov[m] === 1'b1 && out_ready) dut_rx[m].push_back(od[m]);
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (flush) mq[m].delete();
            else begin
                for (int k = 0; k < mq[m].size(); k++) mq[m][k].pos = npg[m][k];
                if (mq[m].size() > 0 && mq[m][0].pos == dep[m]) void'(mq[m].pop_front());
                if (acc[m]) mq[m].push_back(word_t'{data: in_data, pos: 0});
            end
        end
    endtask

    task automatic clear_rx();
        for (int m = 0; m < 2; m++) dut_rx[m].delete();
    endtask

    task automatic test_reset();
        #12;
        clr_n = 0;
        #1;
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (ov[m] !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid m%0d: got %b exp 0", m, ov[m]); end
            n_cmp++; if (od[m] !== rst_val[m]) begin n_bad++; $display("FAIL reset_out_data m%0d: got %h exp %h", m, od[m], rst_val[m]); end
            n_cmp++; if (ir[m] !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready m%0d: got %b exp 1", m, ir[m]); end
`ifdef DFF_PIPE_OCC_EN
            n_cmp++; if (occ_of(m) != 0) begin n_bad++; $display("FAIL reset_occ m%0d: got %0d exp 0", m, occ_of(m)); end
`endif
        end
        flush = 1;
        #1;
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (ir[m] !== 1'b0) begin n_bad++; $display("FAIL reset_flush_in_ready m%0d: got %b exp 0", m, ir[m]); end
        end
        flush = 0;
        for (int m = 0; m < 2; m++) mq[m].delete();
        @(negedge clk);
        clr_n = 1;
    endtask

    task automatic test_streaming();
        int first4 = -1;
        clear_rx();
        for (int i = 0; i < 22; i++) begin
            drive(i < 16, 8'(i + 1), 1, 0);
            for (int m = 0; m < 2; m++) begin
                n_cmp++; if (ir[m] !== exp_ir[m] || (i < 16 && ir[m] !== 1'b1)) begin n_bad++; $display("FAIL stream_in_ready m%0d cyc %0d: got %b exp %b", m, i, ir[m], exp_ir[m]); end
                n_cmp++; if (ov[m] !== exp_ov[m]) begin n_bad++; $display("FAIL stream_out_valid m%0d cyc %0d: got %b exp %b", m, i, ov[m], exp_ov[m]); end
                if (exp_ov[m]) begin
                    n_cmp++; if (od[m] !== exp_od[m]) begin n_bad++; $display("FAIL stream_out_data m%0d cyc %0d: got %h exp %h", m, i, od[m], exp_od[m]); end
                end
            end
            if (ov[0] === 1'b1 && first4 < 0) first4 = i;
            step();
        end
        n_cmp++; if (first4 != 4) begin n_bad++; $display("FAIL stream_latency: got cycle %0d exp 4", first4); end
        for (int m = 0; m < 2; m++) begin
            bit ok = dut_rx[m].size() == 16;
            for (int k = 0; ok && k < 16; k++) ok = dut_rx[m][k] == 8'(k + 1);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL stream_order m%0d: got %0d words exp 16 in order 01..10", m, dut_rx[m].size()); end
        end
    endtask

    task automatic test_stall();
        int acc [2] = '{0, 0};
        clear_rx();
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'(8'h40 + i), 0, 0);
            for (int m = 0; m < 2; m++) if (ir[m] === 1'b1) acc[m]++;
            step();
        end
        drive(1, 8'h4F, 0, 0);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (acc[m] != dep[m]) begin n_bad++; $display("FAIL stall_accepted m%0d: got %0d exp %0d", m, acc[m], dep[m]); end
            n_cmp++; if (ir[m] !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready m%0d: got %b exp 0", m, ir[m]); end
`ifdef DFF_PIPE_OCC_EN
            n_cmp++; if (occ_of(m) != dep[m]) begin n_bad++; $display("FAIL stall_occ m%0d: got %0d exp %0d", m, occ_of(m), dep[m]); end
`endif
        end
        step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 8'h00, 1, 0);
            step();
        end
        for (int m = 0; m < 2; m++) begin
            bit ok = dut_rx[m].size() == dep[m];
            for (int k = 0; ok && k < dep[m]; k++) ok = dut_rx[m][k] == 8'(8'h40 + k);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_drain_order m%0d: got %0d words exp %0d from 40", m, dut_rx[m].size(), dep[m]); end
        end
    endtask

    task automatic test_bubble();
        clear_rx();
        drive(1, 8'h11, 0, 0); step();
        drive(0, 8'h00, 0, 0); step();
        drive(0, 8'h00, 0, 0); step();
        drive(1, 8'h22, 0, 0); step();
        drive(0, 8'h00, 0, 0); step();
        drive(0, 8'h00, 0, 0);
        n_cmp++; if (ir[0] !== 1'b1 || ir[0] !== exp_ir[0]) begin n_bad++; $display("FAIL bubble_in_ready m0: got %b exp 1", ir[0]); end
        n_cmp++; if (ir[1] !== 1'b0) begin n_bad++; $display("FAIL bubble_in_ready m1: got %b exp 0", ir[1]); end
        n_cmp++; if (ov[0] !== 1'b1 || od[0] !== 8'h11) begin n_bad++; $display("FAIL bubble_head m0: got %b/%h exp 1/11", ov[0], od[0]); end
`ifdef DFF_PIPE_OCC_EN
        n_cmp++; if (occ4 != 3'd2) begin n_bad++; $display("FAIL bubble_occ m0: got %0d exp 2", occ4); end
`endif
        step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 8'h00, 1, 0);
            step();
        end
        n_cmp++; if (dut_rx[0].size() != 2 || dut_rx[0][0] != 8'h11 || dut_rx[0][1] != 8'h22) begin n_bad++; $display("FAIL bubble_drain m0: got %0d words exp 11,22", dut_rx[0].size()); end
        n_cmp++; if (dut_rx[1].size() != 1 || dut_rx[1][0] != 8'h11) begin n_bad++; $display("FAIL bubble_drain m1: got %0d words exp 11", dut_rx[1].size()); end
    endtask

    task automatic test_flush();
        clear_rx();
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'(8'h31 + i), 0, 0);
            step();
        end
        drive(1, 8'h99, 0, 1);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (ir[m] !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready m%0d: got %b exp 0", m, ir[m]); end
            n_cmp++; if (ov[m] !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid m%0d: got %b exp 0", m, ov[m]); end
        end
        step();
        drive(0, 8'h00, 0, 0);
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (ov[m] !== 1'b0 || ir[m] !== 1'b1) begin n_bad++; $display("FAIL flush_after m%0d: got valid %b ready %b exp 0 1", m, ov[m], ir[m]); end
`ifdef DFF_PIPE_OCC_EN
            n_cmp++; if (occ_of(m) != 0) begin n_bad++; $display("FAIL flush_occ m%0d: got %0d exp 0", m, occ_of(m)); end
`endif
        end
        step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 8'h00, 1, 0);
            step();
        end
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dut_rx[m].size() != 0) begin n_bad++; $display("FAIL flush_leak m%0d: got %0d words exp 0", m, dut_rx[m].size()); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want [2][$];
        clear_rx();
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'(8'h50 + i), 0, 0);
            step();
        end
        want[0] = '{8'h50, 8'h51, 8'h52, 8'h53};
        want[1] = '{8'h50};
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'(8'h60 + i), 1, 0);
            for (int m = 0; m < 2; m++) begin
                n_cmp++; if (ir[m] !== 1'b1 || ov[m] !== 1'b1) begin n_bad++; $display("FAIL b2b_handshake m%0d cyc %0d: got ready %b valid %b exp 1 1", m, i, ir[m], ov[m]); end
`ifdef DFF_PIPE_OCC_EN
                n_cmp++; if (occ_of(m) != dep[m]) begin n_bad++; $display("FAIL b2b_occ m%0d cyc %0d: got %0d exp %0d", m, i, occ_of(m), dep[m]); end
`endif
                want[m].push_back(8'(8'h60 + i));
            end
            step();
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 8'h00, 1, 0);
            step();
        end
        for (int m = 0; m < 2; m++) begin
            bit ok = dut_rx[m].size() == want[m].size();
            for (int k = 0; ok && k < want[m].size(); k++) ok = dut_rx[m][k] == want[m][k];
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_order m%0d: got %0d words exp %0d", m, dut_rx[m].size(), want[m].size()); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
            for (int m = 0; m < 2; m++) begin
                n_cmp++; if (ir[m] !== exp_ir[m]) begin n_bad++; $display("FAIL rnd_in_ready m%0d cyc %0d: got %b exp %b", m, i, ir[m], exp_ir[m]); end
                n_cmp++; if (ov[m] !== exp_ov[m]) begin n_bad++; $display("FAIL rnd_out_valid m%0d cyc %0d: got %b exp %b", m, i, ov[m], exp_ov[m]); end
                if (exp_ov[m]) begin
                    n_cmp++; if (od[m] !== exp_od[m]) begin n_bad++; $display("FAIL rnd_out_data m%0d cyc %0d: got %h exp %h", m, i, od[m], exp_od[m]); end
                end
`ifdef DFF_PIPE_OCC_EN
                n_cmp++; if (occ_of(m) != mq[m].size()) begin n_bad++; $display("FAIL rnd_occ m%0d cyc %0d: got %0d exp %0d", m, i, occ_of(m), mq[m].size()); end
`endif
            end
            step();
        end
    endtask

    task automatic test_midreset();
        clear_rx();
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'(8'h70 + i), 0, 0);
            step();
        end
        @(negedge clk);
        in_valid = 0;
        #2;
        clr_n = 0;
        #1;
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (ov[m] !== 1'b0 || od[m] !== rst_val[m] || ir[m] !== 1'b1) begin n_bad++; $display("FAIL midreset m%0d: got valid %b data %h ready %b exp 0 %h 1", m, ov[m], od[m], ir[m], rst_val[m]); end
            mq[m].delete();
        end
        @(negedge clk);
        clr_n = 1;
        for (int i = 0; i < 6; i++) begin
            drive(0, 8'h00, 1, 0);
            step();
        end
        for (int m = 0; m < 2; m++) begin
            n_cmp++; if (dut_rx[m].size() != 0) begin n_bad++; $display("FAIL midreset_leak m%0d: got %0d words exp 0", m, dut_rx[m].size()); end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_bubble();
        test_flush();
        test_back_to_back();
        test_random();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
